// File: rtl/set_assoc_cache_v2.sv
// ---------------------------------------------------------------------------
// set_assoc_cache_v2
//
// Write-through, set-associative, one-word-per-line cache between a core
// request port and a memory request port. Reads that hit are answered from
// the line store; read misses, all writes and uncached accesses go to memory.
// Victims are the lowest-index invalid way, otherwise a per-set round-robin
// pointer. A flush request invalidates every line in a single cycle.
//
// Optional feature macro: CACHE_STATS_EN
//   defined   : hit_count_o / miss_count_o count cacheable lookups (saturating)
//   undefined : both counter ports are tied to zero, no counter logic exists
//
// Ports
//   clk, reset_n                     clock, synchronous active-low reset
//   core_addr_i/wdata_i/we_i/req_i/be_i   core request
//   core_rdata_o/gnt_o/rvalid_o/error_o   core grant and response
//   mem_addr_o/wdata_o/we_o/req_o/be_o    memory request
//   mem_rdata_i/gnt_i/rvalid_i/error_i    memory grant and response
//   flush_i, flush_done_o            invalidate-all request and done pulse
//   hit_count_o, miss_count_o        statistics counters
// ---------------------------------------------------------------------------
module set_assoc_cache_v2 #(
    parameter int unsigned WAYS           = 2,
    parameter int unsigned SETS           = 64,
    parameter bit          WRITE_ALLOCATE = 1'b0,
    parameter logic [31:0] UNCACHED_BASE  = 32'h1A00_0000,
    parameter logic [31:0] UNCACHED_MASK  = 32'hFF00_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic        core_we_i,
    input  logic        core_req_i,
    input  logic [3:0]  core_be_i,
    output logic [31:0] core_rdata_o,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic        core_error_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    output logic        mem_req_o,
    output logic [3:0]  mem_be_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_error_i,
    input  logic        flush_i,
    output logic        flush_done_o,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
);

    localparam int unsigned IDX = $clog2(SETS);
    localparam int unsigned TW  = 32 - IDX - 2;
    localparam int unsigned WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP, FLUSH
    } state_t;

    state_t state, state_nxt;

    // Line store
    logic [WAYS-1:0] valid_q [SETS];
    logic [WW-1:0]   rr_q    [SETS];
    logic [TW-1:0]   tag_q   [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS];

    // Registered request and response
    logic [31:0]    req_addr;
    logic [31:0]    req_wdata;
    logic           req_we;
    logic [3:0]     req_be;
    logic           req_uncached;
    logic           hit_q;
    logic [WW-1:0]  hit_way_q;
    logic [31:0]    rdata_q;
    logic           err_q;

    logic [IDX-1:0] req_idx;
    logic [TW-1:0]  req_tag;

    assign req_idx = req_addr[IDX+1:2];
    assign req_tag = req_addr[31:IDX+2];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Tag compare: a hit needs exactly one valid way with a matching tag.
    // ------------------------------------------------------------------
    logic [3:0]    match_cnt;
    logic [WW-1:0] match_way;
    logic          lookup_hit;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        match_cnt = '0;
        match_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                match_cnt = match_cnt + 4'd1;
                match_way = WW'(w);
            end
        end
        lookup_hit = (match_cnt == 4'd1);
    end

    // ------------------------------------------------------------------
    // Victim: lowest invalid way, else the set's round-robin pointer.
    // victim_evicts marks that a valid line is displaced (pointer advances).
    // ------------------------------------------------------------------
    logic [WW-1:0] victim_way;
    logic          victim_evicts;

    always_comb begin
        victim_way    = rr_q[req_idx];
        victim_evicts = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (victim_evicts && !valid_q[req_idx][w]) begin
                victim_way    = WW'(w);
                victim_evicts = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line update on an error-free memory response for a cacheable access:
    // read-miss fill, write-hit byte merge, or write-allocate fill.
    // ------------------------------------------------------------------
    logic          line_we;
    logic          line_fill;
    logic [WW-1:0] line_way;
    logic [31:0]   line_data;

    always_comb begin
        line_we   = 1'b0;
        line_fill = 1'b0;
        line_way  = victim_way;
        line_data = '0;
        if ((state == MEM_WAIT) && mem_rvalid_i && !mem_error_i && !req_uncached) begin
            if (!req_we) begin
                if (!hit_q) begin
                    line_we   = 1'b1;
                    line_fill = 1'b1;
                    line_data = mem_rdata_i;
                end
            end else if (hit_q) begin
                line_we   = 1'b1;
                line_way  = hit_way_q;
                line_data = merge_bytes(data_q[req_idx][hit_way_q], req_wdata, req_be);
            end else if (WRITE_ALLOCATE) begin
                line_we   = 1'b1;
                line_fill = 1'b1;
                line_data = merge_bytes(32'h0, req_wdata, req_be);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        core_gnt_o    = 1'b0;
        core_rvalid_o = 1'b0;
        flush_done_o  = 1'b0;
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_we_o      = 1'b0;
        mem_be_o      = '0;
        unique case (state)
            IDLE: begin
                if (flush_i) begin
                    state_nxt = FLUSH;
                end else if (core_req_i) begin
                    // No grant while reset is held: the request would be lost.
                    core_gnt_o = reset_n;
                    state_nxt  = LOOKUP;
                end
            end
            LOOKUP: begin
                state_nxt = (!req_uncached && !req_we && lookup_hit) ? RESP : MEM_REQ;
            end
            MEM_REQ: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = req_addr;
                mem_we_o    = req_we;
                mem_wdata_o = req_we ? req_wdata : 32'h0;
                mem_be_o    = req_we ? req_be : 4'b1111;
                if (mem_gnt_i) state_nxt = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_rvalid_i) state_nxt = RESP;
            end
            RESP: begin
                core_rvalid_o = 1'b1;
                state_nxt     = IDLE;
            end
            FLUSH: begin
                flush_done_o = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign core_rdata_o = rdata_q;
    assign core_error_o = core_rvalid_o & err_q;

    // ------------------------------------------------------------------
    // State, request/response registers, valid bits and pointers
    // ------------------------------------------------------------------
    // NOTE: all sequential state is assigned with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_we       <= 1'b0;
            req_be       <= '0;
            req_uncached <= 1'b0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state <= state_nxt;

            if (core_gnt_o) begin
                req_addr     <= core_addr_i;
                req_wdata    <= core_wdata_i;
                req_we       <= core_we_i;
                req_be       <= core_be_i;
                req_uncached <= ((core_addr_i & UNCACHED_MASK) == UNCACHED_BASE);
            end

            if (state == LOOKUP) begin
                hit_q     <= lookup_hit && !req_uncached;
                hit_way_q <= match_way;
                rdata_q   <= data_q[req_idx][match_way];
                err_q     <= 1'b0;
            end

            if ((state == MEM_WAIT) && mem_rvalid_i) begin
                rdata_q <= req_we ? 32'h0 : mem_rdata_i;
                err_q   <= mem_error_i;
            end

            if (state == FLUSH) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    rr_q[s]    <= '0;
                end
            end else if (line_fill) begin
                valid_q[req_idx][line_way] <= 1'b1;
                if (victim_evicts) begin
                    rr_q[req_idx] <= (rr_q[req_idx] == WW'(WAYS - 1)) ? '0
                                                                        : rr_q[req_idx] + WW'(1);
                end
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; the valid bits alone decide
    // whether a line's contents mean anything, so they stay plain RAM.
    always_ff @(posedge clk) begin
        if (reset_n && line_we) begin
            data_q[req_idx][line_way] <= line_data;
            if (line_fill) tag_q[req_idx][line_way] <= req_tag;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n || (state == FLUSH)) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if ((state == LOOKUP) && !req_uncached) begin
            if (lookup_hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = 32'h0;
    assign miss_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_set_assoc_cache_v2.sv
// ---------------------------------------------------------------------------
// tb_set_assoc_cache_v2
//
// Directed scenarios followed by random accesses for set_assoc_cache_v2 with
// default parameters (2 ways, 64 sets, no write allocate). The bench acts as
// core and memory, and predicts every response from an abstract model of the
// cache (per-set way arrays plus a round-robin index) and a sparse memory.
// ---------------------------------------------------------------------------
module tb_set_assoc_cache_v2;

    localparam int WAYS = 2;
    localparam int SETS = 64;
    localparam bit WA   = 1'b0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] core_addr_i, core_wdata_i;
    logic        core_we_i, core_req_i;
    logic [3:0]  core_be_i;
    logic [31:0] core_rdata_o;
    logic        core_gnt_o, core_rvalid_o, core_error_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_we_o, mem_req_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_gnt_i, mem_rvalid_i, mem_error_i;
    logic        flush_i, flush_done_o;
    logic [31:0] hit_count_o, miss_count_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    set_assoc_cache_v2 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_we_i    (core_we_i),
        .core_req_i   (core_req_i),
        .core_be_i    (core_be_i),
        .core_rdata_o (core_rdata_o),
        .core_gnt_o   (core_gnt_o),
        .core_rvalid_o(core_rvalid_o),
        .core_error_o (core_error_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_we_o     (mem_we_o),
        .mem_req_o    (mem_req_o),
        .mem_be_o     (mem_be_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_error_i  (mem_error_i),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    bit          m_valid [SETS][WAYS];
    logic [23:0] m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS];
    int          m_rr    [SETS];
    int          m_hits, m_misses;
    logic [31:0] mem_model [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    function automatic bit is_unc(input logic [31:0] a);
        return (a & 32'hFF00_0000) == 32'h1A00_0000;
    endfunction

    function automatic int find_hit(input logic [31:0] a);
        int s, n, wf;
        s = int'(a[7:2]); n = 0; wf = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[31:8]) begin n++; wf = w; end
        return (n == 1) ? wf : -1;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = $urandom;
        return mem_model[a];
    endfunction

    task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
        int s, v;
        s = int'(a[7:2]); v = -1;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && v < 0) v = w;
        if (v < 0) begin v = m_rr[s]; m_rr[s] = (m_rr[s] + 1) % WAYS; end
        m_valid[s][v] = 1'b1; m_tag[s][v] = a[31:8]; m_data[s][v] = d;
    endtask

    task automatic model_clear(input bit counters);
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        if (counters) begin m_hits = 0; m_misses = 0; end
    endtask

    task automatic check_counters(input string tag);
`ifdef CACHE_STATS_EN
        check({tag, "_hits"}, hit_count_o, m_hits);
        check({tag, "_misses"}, miss_count_o, m_misses);
`else
        check({tag, "_hits"}, hit_count_o, 32'h0);
        check({tag, "_misses"}, miss_count_o, 32'h0);
`endif
    endtask

    // One core access, acting as memory too; all expectations from the model.
    task automatic do_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input logic [3:0] be, input bit merr, input bit with_flush,
                             output int nreq, output int lat, output logic [31:0] rdata);
        bit unc, exp_hit, got;
        int hw, c0, fd, gcyc, gd, rd, phase, s;
        logic [31:0] memval, exp_rdata;
        logic obs_err;
        if (with_flush) model_clear(1'b1);
        s = int'(addr[7:2]);
        unc = is_unc(addr);
        hw = unc ? -1 : find_hit(addr);
        exp_hit = !unc && !we && (hw >= 0);
        memval = mem_read(addr);
        exp_rdata = exp_hit ? m_data[s][hw] : memval;
        nreq = 0; lat = -1; rdata = 'x; obs_err = 1'b0;
        c0 = 0; fd = -1; gcyc = -1; got = 1'b0;

        @(posedge clk); #1;
        core_req_i = 1'b1; core_addr_i = addr; core_we_i = we;
        core_wdata_i = wdata; core_be_i = be;
        if (with_flush) flush_i = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (i == 0) c0 = cyc;
            if (flush_done_o) fd = cyc;
            if (core_gnt_o) begin got = 1'b1; gcyc = cyc; end
            else begin @(posedge clk); #1; if (fd >= 0) flush_i = 1'b0; end
        end
        if (!got) begin
            check("gnt_timeout", 32'd0, 32'd1);
            core_req_i = 1'b0; flush_i = 1'b0;
            return;
        end
        if (with_flush) begin
            check("flush_done_cycle", fd - c0, 32'd1);
            check("gnt_after_flush", gcyc - c0, 32'd2);
        end else begin
            check("gnt_same_cycle", gcyc - c0, 32'd0);
        end
        @(posedge clk); #1;
        core_req_i = 1'b0; core_addr_i = $urandom; core_wdata_i = $urandom;
        core_we_i = 1'(~we); core_be_i = 4'($urandom);

        gd = $urandom_range(0, 2); rd = $urandom_range(0, 2); phase = 0;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge clk);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_error_i = 1'b0;
            if (core_rvalid_o) begin
                lat = cyc - gcyc; rdata = core_rdata_o; obs_err = core_error_o;
            end else if (mem_req_o) begin
                check("mem_addr", mem_addr_o, addr);
                check("mem_we", 32'(mem_we_o), 32'(we));
                check("mem_be", 32'(mem_be_o), we ? 32'(be) : 32'hF);
                if (we) check("mem_wdata", mem_wdata_o, wdata);
                if (gd == 0) begin mem_gnt_i = 1'b1; nreq++; phase = 1; end
                else gd--;
            end else if (phase == 1) begin
                if (rd == 0) begin
                    mem_rvalid_i = 1'b1; mem_error_i = merr;
                    mem_rdata_i = we ? $urandom : memval;
                    phase = 2;
                end else rd--;
            end
        end
        if (lat < 0) begin
            check("rvalid_timeout", 32'd0, 32'd1);
            return;
        end
        check("mem_requests", nreq, exp_hit ? 32'd0 : 32'd1);
        if (exp_hit) check("hit_latency", lat, 32'd2);
        if (!we) check("rdata", rdata, exp_rdata);
        check("error", 32'(obs_err), exp_hit ? 32'd0 : 32'(merr));
        @(negedge clk);
        check("rvalid_one_cycle", 32'(core_rvalid_o), 32'd0);
        check("error_idle", 32'(core_error_o), 32'd0);

        // model update
        if (we && !merr) mem_model[addr] = merge(memval, wdata, be);
        if (!unc) begin
            if (hw >= 0) m_hits++; else m_misses++;
            if (!we) begin
                if (hw < 0 && !merr) model_fill(addr, memval);
            end else if (!merr) begin
                if (hw >= 0) m_data[s][hw] = merge(m_data[s][hw], wdata, be);
                else if (WA) model_fill(addr, merge(32'h0, wdata, be));
            end
        end
        check_counters("stats");
    endtask

    task automatic do_flush();
        @(posedge clk); #1; flush_i = 1'b1;
        @(negedge clk); check("flush_done_pre", 32'(flush_done_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("flush_done", 32'(flush_done_o), 32'd1);
        @(posedge clk); #1; flush_i = 1'b0;
        @(negedge clk); check("flush_done_post", 32'(flush_done_o), 32'd0);
        model_clear(1'b1);
        check_counters("flush");
    endtask

    initial begin
        int nreq, lat;
        logic [31:0] rdata, a;

        reset_n = 1'b0; core_req_i = 1'b1; core_addr_i = 32'h100; core_wdata_i = '0;
        core_we_i = 1'b0; core_be_i = 4'hF; mem_rdata_i = '0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_error_i = 1'b0; flush_i = 1'b0;
        model_clear(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(core_gnt_o), 32'd0);
        check("rst_rvalid", 32'(core_rvalid_o), 32'd0);
        check("rst_error", 32'(core_error_o), 32'd0);
        check("rst_rdata", core_rdata_o, 32'd0);
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_be", 32'(mem_be_o), 32'd0);
        check("rst_mem_we", 32'(mem_we_o), 32'd0);
        check("rst_flush_done", 32'(flush_done_o), 32'd0);
        check_counters("rst");
        core_req_i = 1'b0;
        @(posedge clk); #1; reset_n = 1'b1;

        // Read miss then read hit
        do_flush();
        mem_model[32'h100] = 32'hDEADBEEF;
        do_access(32'h100, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        check("d1_miss_req", nreq, 32'd1);
        do_access(32'h100, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        check("d1_hit_req", nreq, 32'd0);
        check("d1_hit_lat", lat, 32'd2);
        check("d1_hit_rdata", rdata, 32'hDEADBEEF);

        // Conflict eviction in set 0
        do_flush();
        do_access(32'h000, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        do_access(32'h100, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        do_access(32'h200, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        check("d2_third_miss", nreq, 32'd1);
        do_access(32'h100, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        check("d2_reread_hit", nreq, 32'd0);
        do_access(32'h000, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        check("d2_evicted_miss", nreq, 32'd1);

        // Partial write hit merges enabled bytes
        do_flush();
        mem_model[32'h100] = 32'h11223344;
        do_access(32'h100, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        do_access(32'h100, 1'b1, 32'hAABBCCDD, 4'b0011, 1'b0, 1'b0, nreq, lat, rdata);
        check("d3_write_req", nreq, 32'd1);
        do_access(32'h100, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        check("d3_reread_hit", nreq, 32'd0);
        check("d3_merged", rdata, 32'h1122CCDD);

        // Uncached reads always go to memory
        do_access(32'h1A00_0010, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        check("d4_unc_first", nreq, 32'd1);
        do_access(32'h1A00_0010, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        check("d4_unc_second", nreq, 32'd1);

        // Flush beats a simultaneous request; the prior hit now misses
        do_access(32'h100, 1'b0, 0, 4'hF, 1'b0, 1'b1, nreq, lat, rdata);
        check("d5_after_flush_miss", nreq, 32'd1);

        // Reset during MEM_WAIT abandons the transaction
        @(posedge clk); #1;
        core_req_i = 1'b1; core_addr_i = 32'h300; core_we_i = 1'b0; core_be_i = 4'hF;
        @(negedge clk); check("d6_gnt", 32'(core_gnt_o), 32'd1);
        @(posedge clk); #1; core_req_i = 1'b0;
        @(negedge clk);
        @(negedge clk); check("d6_mem_req", 32'(mem_req_o), 32'd1); mem_gnt_i = 1'b1;
        @(negedge clk); mem_gnt_i = 1'b0; reset_n = 1'b0;
        @(negedge clk);
        check("d6_rst_mem_req", 32'(mem_req_o), 32'd0);
        check("d6_rst_rvalid", 32'(core_rvalid_o), 32'd0);
        reset_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555AAAA;
        @(negedge clk); mem_rvalid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("d6_no_rvalid", 32'(core_rvalid_o), 32'd0);
            check("d6_no_mem_req", 32'(mem_req_o), 32'd0);
            @(negedge clk);
        end
        model_clear(1'b1);
        check_counters("d6");
        do_access(32'h300, 1'b0, 0, 4'hF, 1'b0, 1'b0, nreq, lat, rdata);
        check("d6_line_invalid", nreq, 32'd1);

        // Random traffic over a small address pool
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = 32'h1A00_0000 | (32'($urandom_range(0, 3)) << 2);
            else
                a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
            do_access(a, 1'($urandom_range(0, 2) == 0), $urandom, 4'($urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                      nreq, lat, rdata);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
